// File: rtl/vga_pkg.sv
// Shared VGA timing widths, character-grid geometry and pipeline bundles
// used by the text-overlay renderer.
package vga_pkg;

  localparam int HC_W          = 11;
  localparam int RGB_W         = 12;
  localparam int CHAR_W        = 8;
  localparam int CHAR_H        = 16;
  localparam int GRID          = 16;
  localparam int DRAW_CHAR_LAT = 4;

  // Text rectangle is a GRID x GRID array of CHAR_W x CHAR_H cells.
  localparam int RECT_W = CHAR_W * GRID;
  localparam int RECT_H = CHAR_H * GRID;

  // Timing + colour bundle carried alongside the address pipeline.
  typedef struct packed {
    logic [HC_W-1:0]  hcount;
    logic [HC_W-1:0]  vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
  } vga_bus_t;

  // Per-pixel glyph position captured in stage 1.
  typedef struct packed {
    logic       in_rect;
    logic [3:0] line;
    logic [2:0] bit_idx;
  } char_meta_t;

  // Subset still needed once the font row address has been issued.
  typedef struct packed {
    logic       in_rect;
    logic [2:0] bit_idx;
  } pix_sel_t;

endpackage

// File: rtl/draw_rect_char_delay.sv
// Fixed-latency shift register; synchronous reset clears every stage.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [CLK_DEL-1:0][WIDTH-1:0] pipe_q, pipe_d;

  // Shift the bundle one stage per clock.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = din;
    for (int i = 1; i < CLK_DEL; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Stage registers; reset flushes the whole chain.
  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign dout = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_rect_char.sv
// Text-overlay renderer: maps the scan position onto a 16x16 character
// grid, fetches code and font row from external ROMs, and overlays the
// glyph colour on the incoming pixel stream with a fixed 4-clk latency.
module draw_rect_char
  import vga_pkg::*;
#(
  parameter logic [10:0] XPOS         = 11'd100,
  parameter logic [10:0] YPOS         = 11'd50,
  parameter logic [11:0] LETTER_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [6:0]  char_code,
  input  logic [7:0]  char_pixels,
  output logic [7:0]  char_xy,
  output logic [10:0] char_addr,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Bounds on 12 bits so XPOS+RECT_W cannot wrap.
  localparam logic [11:0] X_LO = {1'b0, XPOS};
  localparam logic [11:0] X_HI = X_LO + 12'(RECT_W);
  localparam logic [11:0] Y_LO = {1'b0, YPOS};
  localparam logic [11:0] Y_HI = Y_LO + 12'(RECT_H);

  logic [6:0]  rel_x;
  logic [7:0]  rel_y;
  logic        in_rect;
  char_meta_t  meta_in, meta_s1;
  logic [3:0]  line_s2;
  pix_sel_t    pix_s3;
  vga_bus_t    bus_in, bus_s3, out_d, out_q;
  logic [7:0]  char_xy_d, char_xy_q;
  logic        pix;

  // Stage 0: rectangle test and cell/line/bit split of the scan position.
  // Only the low bits of the offsets matter inside a 128x256 rectangle.
  always_comb begin
    rel_x   = hcount_in[6:0] - XPOS[6:0];
    rel_y   = vcount_in[7:0] - YPOS[7:0];
    in_rect = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
              ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);
    char_xy_d       = {rel_y[7:4], rel_x[6:3]};
    meta_in.in_rect = in_rect;
    meta_in.line    = rel_y[3:0];
    meta_in.bit_idx = rel_x[2:0];
    bus_in.hcount   = hcount_in;
    bus_in.vcount   = vcount_in;
    bus_in.hsync    = hsync_in;
    bus_in.vsync    = vsync_in;
    bus_in.hblnk    = hblnk_in;
    bus_in.vblnk    = vblnk_in;
    bus_in.rgb      = rgb_in;
  end

  // Stage 1: cell address to the character-code ROM, registered every clk.
  always_ff @(posedge clk) begin
    if (rst) char_xy_q <= '0;
    else     char_xy_q <= char_xy_d;
  end

  assign char_xy = char_xy_q;

  delay #(.WIDTH($bits(char_meta_t)), .CLK_DEL(1)) u_meta_s1 (
    .clk (clk),
    .rst (rst),
    .din (meta_in),
    .dout(meta_s1)
  );

  // Stage 2: glyph line travels with the returned char_code.
  delay #(.WIDTH(4), .CLK_DEL(1)) u_line_s2 (
    .clk (clk),
    .rst (rst),
    .din (meta_s1.line),
    .dout(line_s2)
  );

  assign char_addr = {char_code, line_s2};

  // Stage 3: pixel select info lines up with the font row.
  delay #(.WIDTH($bits(pix_sel_t)), .CLK_DEL(2)) u_pix_s3 (
    .clk (clk),
    .rst (rst),
    .din ({meta_s1.in_rect, meta_s1.bit_idx}),
    .dout(pix_s3)
  );

  // Timing and background colour ride three stages, the output register adds the fourth.
  delay #(.WIDTH($bits(vga_bus_t)), .CLK_DEL(DRAW_CHAR_LAT-1)) u_bus_s3 (
    .clk (clk),
    .rst (rst),
    .din (bus_in),
    .dout(bus_s3)
  );

  // Stage 4 compose: blanking wins, then glyph pixels, else background.
  always_comb begin
    pix   = char_pixels[3'd7 - pix_s3.bit_idx];
    out_d = bus_s3;
    if (bus_s3.hblnk || bus_s3.vblnk) out_d.rgb = '0;
    else if (pix_s3.in_rect && pix)   out_d.rgb = LETTER_COLOR;
    else                              out_d.rgb = bus_s3.rgb;
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign hcount_out = out_q.hcount;
  assign vcount_out = out_q.vcount;
  assign hsync_out  = out_q.hsync;
  assign vsync_out  = out_q.vsync;
  assign hblnk_out  = out_q.hblnk;
  assign vblnk_out  = out_q.vblnk;
  assign rgb_out    = out_q.rgb;

endmodule

// File: tb/tb_draw_rect_char.sv
// Bench for draw_rect_char: ROM models, directed and random pixel stream,
// expectations from a rectangle/glyph reference model over an input history.
module tb_draw_rect_char;

  localparam int XI = 100;
  localparam int YI = 50;
  localparam int LC = 'hFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_in, rgb_out;
  logic [6:0]  char_code;
  logic [7:0]  char_pixels, char_xy;
  logic [10:0] char_addr;

  logic [6:0] code_rom [256];
  logic [7:0] font_rom [2048];

  typedef struct {
    bit r;
    int h, v;
    bit hs, vs, hb, vb;
    int rgb;
  } ent_t;

  ent_t hist [8192];
  int   cyc, n_chk, n_fail;

  always #5 clk = ~clk;

  draw_rect_char #(.XPOS(11'd100), .YPOS(11'd50), .LETTER_COLOR(12'hFFF)) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .char_code(char_code), .char_pixels(char_pixels),
    .char_xy(char_xy), .char_addr(char_addr),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // Registered ROMs: data valid one clock after the address.
  always_ff @(posedge clk) begin
    char_code   <= code_rom[char_xy];
    char_pixels <= font_rom[char_addr];
  end

  function automatic bit rst_at(int j);
    return (j < 0) || hist[j].r;
  endfunction

  function automatic bit inr(ent_t e);
    return e.h >= XI && e.h < XI + 128 && e.v >= YI && e.v < YI + 256;
  endfunction

  function automatic int cell_of(ent_t e);
    return ((e.v - YI) / 16) * 16 + (e.h - XI) / 8;
  endfunction

  function automatic int addr_of(ent_t e);
    return int'(code_rom[cell_of(e)]) * 16 + (e.v - YI) % 16;
  endfunction

  function automatic int exp_rgb(ent_t e);
    logic [7:0] row;
    if (e.hb || e.vb) return 0;
    if (inr(e)) begin
      row = font_rom[addr_of(e)];
      if (row[7 - (e.h - XI) % 8]) return LC;
    end
    return e.rgb;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  // Compare every output against the history entry it should reflect.
  task automatic check();
    int   k;
    bit   anyr;
    ent_t e;
    k    = cyc;
    anyr = rst_at(k-1) || rst_at(k-2) || rst_at(k-3) || rst_at(k-4);
    if (anyr) begin
      chk("rst_rgb",    32'(rgb_out),    0);
      chk("rst_hcount", 32'(hcount_out), 0);
      chk("rst_vcount", 32'(vcount_out), 0);
      chk("rst_ctl",    32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 0);
    end else begin
      e = hist[k-4];
      chk("rgb_out",    32'(rgb_out),    32'(exp_rgb(e)));
      chk("hcount_out", 32'(hcount_out), 32'(e.h));
      chk("vcount_out", 32'(vcount_out), 32'(e.v));
      chk("ctl_out",    32'({hsync_out, vsync_out, hblnk_out, vblnk_out}),
          32'({e.hs, e.vs, e.hb, e.vb}));
    end
    if (rst_at(k-1)) chk("rst_char_xy", 32'(char_xy), 0);
    else if (inr(hist[k-1])) chk("char_xy", 32'(char_xy), 32'(cell_of(hist[k-1])));
    if (!rst_at(k-1) && !rst_at(k-2) && inr(hist[k-2]))
      chk("char_addr", 32'(char_addr), 32'(addr_of(hist[k-2])));
  endtask

  task automatic drive(bit r, int h, int v, bit hs, bit vs, bit hb, bit vb, int rgb);
    logic [10:0] hh, vv;
    logic [11:0] cc;
    hh = 11'(h); vv = 11'(v); cc = 12'(rgb);
    rst = r; hcount_in = hh; vcount_in = vv;
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = cc;
    hist[cyc] = '{r, int'(hh), int'(vv), hs, vs, hb, vb, int'(cc)};
    @(posedge clk);
    #1;
    cyc++;
    check();
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill_roms(bit all_ff);
    for (int i = 0; i < 256; i++) code_rom[i] = 7'($urandom);
    for (int i = 0; i < 2048; i++) font_rom[i] = all_ff ? 8'hFF : 8'($urandom);
  endtask

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0;
    fill_roms(0);
    code_rom[0]      = 7'h57;
    font_rom[11'h570] = 8'h80;

    // Reset state.
    for (int i = 0; i < 3; i++) drive(1, 150, 60, 1, 1, 0, 0, 'h5A5);

    // Address path, pixel select, cell mapping and last row/column.
    drive(0, 100, 50,  0, 0, 0, 0, 'h123);
    drive(0, 101, 50,  0, 0, 0, 0, 'h123);
    drive(0, 124, 242, 1, 0, 0, 0, 'h456);
    drive(0, 227, 305, 0, 1, 0, 0, 'h789);
    drive(0, 220, 305, 0, 0, 0, 0, 'hABC);
    drain();

    // Edges and blanking with every font pixel set.
    fill_roms(1);
    drive(0, 99,  50,  0, 0, 0, 0, 'h111);
    drive(0, 228, 50,  0, 0, 0, 0, 'h222);
    drive(0, 100, 49,  0, 0, 0, 0, 'h333);
    drive(0, 100, 306, 0, 0, 0, 0, 'h444);
    drive(0, 227, 305, 1, 1, 0, 0, 'h555);
    drive(0, 100, 50,  1, 0, 1, 0, 'h666);
    drive(0, 150, 100, 0, 1, 0, 1, 'h777);
    drive(0, 160, 120, 1, 1, 1, 1, 'h888);
    drain();

    // Sequential scan of the last glyph row, then randomized traffic
    // with one mid-frame reset pulse.
    fill_roms(0);
    for (int h = 96; h < 232; h++) drive(0, h, YI + 255, 0, 0, 0, 0, $urandom);
    for (int i = 0; i < 1500; i++) begin
      if (i == 700)
        drive(1, $urandom_range(100, 227), $urandom_range(50, 305), 1, 1, 0, 0, $urandom);
      else
        drive(0, $urandom_range(90, 240), $urandom_range(40, 320),
              1'($urandom), 1'($urandom),
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
